// File: rtl/vga_frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// vga_frame_scheduler_if
//   Interface between the per-frame game sequencer and the rest of the game.
//   It carries the video-timing input, the player and collision inputs, and
//   every game-state output. The clock and the resets stay as plain ports on
//   the scheduler.
//
//   Signals:
//     iVS          vertical sync from the sync generator, active-low
//     iCONTROL[1:0] player input (01 right, 10 left, 00/11 none or pause)
//     iCOLLIDE     collision flag at the car lane, valid in blanking
//     oSCROLL_STB  one-cycle strobe: advance the obstacle map one row
//     oCAR_LANE[2:0] current car lane
//     oBUSY        update sequence in progress
//     oGAME_OVER   sticky collision flag
//     oPAUSED      pause state
//     oSCORE[17:0] scrolls survived, saturating
//     oLEVEL[3:0]  current level
//
//   Modports: master = game top / testbench side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface vga_frame_scheduler_if;
  logic        iVS;
  logic [1:0]  iCONTROL;
  logic        iCOLLIDE;
  logic        oSCROLL_STB;
  logic [2:0]  oCAR_LANE;
  logic        oBUSY;
  logic        oGAME_OVER;
  logic        oPAUSED;
  logic [17:0] oSCORE;
  logic [3:0]  oLEVEL;

  modport master (
    output iVS, iCONTROL, iCOLLIDE,
    input  oSCROLL_STB, oCAR_LANE, oBUSY, oGAME_OVER, oPAUSED, oSCORE, oLEVEL
  );

  modport slave (
    input  iVS, iCONTROL, iCOLLIDE,
    output oSCROLL_STB, oCAR_LANE, oBUSY, oGAME_OVER, oPAUSED, oSCORE, oLEVEL
  );
endinterface

// File: rtl/vga_frame_scheduler.sv
// -----------------------------------------------------------------------------
// vga_frame_scheduler
//   Per-frame game sequencer for the VGA car game. On each falling edge of
//   vertical sync it runs a short update sequence inside vertical blanking:
//   latch the player control, move the car lane, advance the frame divider
//   (scrolling the obstacle map when it wraps), check for a collision, and
//   update score and level. Game state never changes during active video.
//
//   Ports:
//     iVGA_CLK   pixel clock, the only clock
//     iRST       synchronous active-high full reset (highest priority)
//     iRST_GAME  synchronous active-high game restart
//     bus        vga_frame_scheduler_if.slave (sync, control, collision in;
//                scroll strobe, lane, busy, game-over, pause, score, level out)
//
//   Parameters:
//     LANES (2..8), BASE_DIV (frames per scroll at level 0),
//     PTS_PER_LEVEL (scrolls per level), LEVEL_MAX (level saturation).
//
//   Build option:
//     FRAME_SCHED_PAUSE_EN  when defined, a fresh press of control 11 toggles
//                           pause; paused frames run only the latch step.
//                           When undefined, 11 means "no movement" and oPAUSED
//                           is tied low.
// -----------------------------------------------------------------------------
module vga_frame_scheduler #(
  parameter int LANES         = 4,
  parameter int BASE_DIV      = 8,
  parameter int PTS_PER_LEVEL = 100,
  parameter int LEVEL_MAX     = 15
) (
  input logic                  iVGA_CLK,
  input logic                  iRST,
  input logic                  iRST_GAME,
  vga_frame_scheduler_if.slave bus
);

  localparam int          DIV_W     = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int          PTS_W     = (PTS_PER_LEVEL > 1) ? $clog2(PTS_PER_LEVEL) : 1;
  localparam logic [2:0]  LANE_RST  = 3'(LANES / 2);
  localparam logic [17:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_MOVE,
    S_SCROLL,
    S_CHECK,
    S_SCORE,
    S_OVER
  } state_t;

  state_t             state_q, state_d;
  logic               vs_q;
  logic [1:0]         hist_q;      // control seen in the previous frame
  logic [1:0]         ctl_q;       // control latched this frame
  logic               press_q;     // control is a fresh, non-idle press
  logic [2:0]         lane_q;
  logic [DIV_W-1:0]   div_q;
  logic               scrolled_q;  // this frame scrolled, so score it
  logic [17:0]        score_q;
  logic [PTS_W-1:0]   pts_q;
  logic [3:0]         level_q;
  logic               over_q;
  logic               paused_q;

  logic clr;
  logic start;
  logic press;
  logic pause_d;
  logic div_wrap;
  int   period;

  // Full reset and game restart clear exactly the same state.
  assign clr   = iRST | iRST_GAME;
  assign start = vs_q & ~bus.iVS;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    press   = (bus.iCONTROL != hist_q) && (bus.iCONTROL != 2'b00);
    pause_d = paused_q;
`ifdef FRAME_SCHED_PAUSE_EN
    if (state_q == S_LATCH && press && bus.iCONTROL == 2'b11) pause_d = ~paused_q;
`endif
    // Scroll period shrinks by one frame per level, never below one frame.
    period = BASE_DIV - int'(level_q);
    if (period < 1) period = 1;
    div_wrap = (int'(div_q) == period - 1);

    state_d         = state_q;
    bus.oBUSY       = 1'b0;
    bus.oSCROLL_STB = 1'b0;

    case (state_q)
      S_IDLE:   if (start) state_d = S_LATCH;
      S_LATCH: begin
        bus.oBUSY = 1'b1;
        // A paused frame stops after latching, including the frame that pauses.
        state_d   = pause_d ? S_IDLE : S_MOVE;
      end
      S_MOVE: begin
        bus.oBUSY = 1'b1;
        state_d   = div_wrap ? S_SCROLL : S_CHECK;
      end
      S_SCROLL: begin
        bus.oBUSY = 1'b1;
        // A reset landing in this cycle aborts the sequence, strobe included.
        bus.oSCROLL_STB = ~clr;
        state_d   = S_CHECK;
      end
      S_CHECK: begin
        bus.oBUSY = 1'b1;
        if (bus.iCOLLIDE)    state_d = S_OVER;
        else if (scrolled_q) state_d = S_SCORE;
        else                 state_d = S_IDLE;
      end
      S_SCORE: begin
        bus.oBUSY = 1'b1;
        state_d   = S_IDLE;
      end
      S_OVER:   state_d = S_OVER;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge iVGA_CLK) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (clr) begin
      vs_q       <= 1'b1;
      hist_q     <= 2'b00;
      ctl_q      <= 2'b00;
      press_q    <= 1'b0;
      lane_q     <= LANE_RST;
      div_q      <= '0;
      scrolled_q <= 1'b0;
      score_q    <= '0;
      pts_q      <= '0;
      level_q    <= '0;
      over_q     <= 1'b0;
    end else begin
      vs_q <= bus.iVS;
      case (state_q)
        S_LATCH: begin
          hist_q  <= bus.iCONTROL;
          ctl_q   <= bus.iCONTROL;
          press_q <= press;
        end
        S_MOVE: begin
          // Lane saturates at both edges; holding a direction moves only once.
          if (press_q && ctl_q == 2'b01 && int'(lane_q) < LANES - 1)
            lane_q <= lane_q + 3'd1;
          else if (press_q && ctl_q == 2'b10 && lane_q != 3'd0)
            lane_q <= lane_q - 3'd1;
          if (div_wrap) div_q <= '0;
          else          div_q <= div_q + DIV_W'(1);
        end
        S_SCROLL: scrolled_q <= 1'b1;
        S_CHECK:  if (bus.iCOLLIDE) over_q <= 1'b1;
        S_SCORE: begin
          scrolled_q <= 1'b0;
          // Once the score saturates, level progress freezes with it.
          if (score_q != SCORE_MAX) begin
            score_q <= score_q + 18'd1;
            if (int'(pts_q) == PTS_PER_LEVEL - 1) begin
              pts_q <= '0;
              if (int'(level_q) < LEVEL_MAX) level_q <= level_q + 4'd1;
            end else begin
              pts_q <= pts_q + PTS_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_SCHED_PAUSE_EN
  always_ff @(posedge iVGA_CLK) begin
    if (clr) paused_q <= 1'b0;
    else     paused_q <= pause_d;
  end
`else
  assign paused_q = 1'b0;
`endif

  assign bus.oCAR_LANE  = lane_q;
  assign bus.oGAME_OVER = over_q;
  assign bus.oPAUSED    = paused_q;
  assign bus.oSCORE     = score_q;
  assign bus.oLEVEL     = level_q;

endmodule
